branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
//   Writer side of the branch predictor's update port and the consumer of its IF-stage predictions.
//   Records each prediction issued at IF in an in-order tracking queue.
//   When EX resolves an instruction, the block pops the matching entry and checks it against the actual outcome.
//   It then drives the predictor update bus (is_branch/ex_pc/b_tar/taken) and issues the pipeline flush/redirect on a mispredict.
//   Sits between IF, EX and the predictor; also keeps branch/mispredict statistics.
// PARAMETERS
//   DEPTH   4   in-flight tracked instructions (power of 2, >=2)
//   AW      32  instruction address width
//   CW      32  statistics counter width
// PORTS
//   clk          in   1    clock
//   rst          in   1    synchronous, active-high reset
//   rdy          in   1    global enable; 0 = freeze all state
//   if_push      in   1    IF issues one instruction this cycle
//   if_pc        in   AW   PC of issued instruction
//   pred_taken   in   1    predictor's taken_o for if_pc
//   pred_tar     in   AW   predictor's b_tar_o for if_pc
//   q_full       out  1    queue full; IF must stall (count==DEPTH)
//   ex_valid     in   1    EX resolves the oldest in-flight instruction
//   ex_pc        in   AW   PC of resolved instruction
//   ex_is_branch in   1    resolved instruction is a branch/jump
//   ex_taken     in   1    actual direction
//   ex_tar       in   AW   actual taken target
//   upd_valid    out  1    to predictor is_branch (1-cycle pulse)
//   upd_pc       out  AW   to predictor ex_pc
//   upd_tar      out  AW   to predictor b_tar_i
//   upd_taken    out  1    to predictor taken_i
//   flush_o      out  1    mispredict flush (1-cycle pulse)
//   redirect_pc  out  AW   correct next PC, valid with flush_o
//   br_cnt       out  CW   resolved branches
//   miss_cnt     out  CW   mispredicts
//   err_o        out  1    sticky protocol error
// BEHAVIOUR
//   Reset: queue empty, q_full=0, all outputs 0, counters 0, err_o=0.
//   Reset has priority over rdy.
//   rdy=0: no state changes; upd_valid and flush_o are gated to 0.
//     Pending pulses are delivered on the first cycle with rdy=1.
//   Queue: circular FIFO with wrapping head/tail pointers and a count of 0..DEPTH.
//     Each entry holds {pc, pred_taken, pred_tar}.
//   Push is accepted if if_push && (count<DEPTH || pop in same cycle).
//     A push while full with no pop is dropped and sets err_o.
//   Pop on ex_valid when count>0.
//     ex_valid on an empty queue sets err_o; no pop, no update.
//     If ex_pc != head.pc, set err_o and still process the entry.
//   Mispredict M, evaluated on a pop (nxt = ex_pc+4, mod 2^AW):
//     ex_is_branch && ex_taken && (!pred_taken || pred_tar!=ex_tar)  -> redirect ex_tar
//     ex_is_branch && !ex_taken && pred_taken                      -> redirect nxt
//     !ex_is_branch && pred_taken                                  -> redirect nxt
//   Latency: a pop in cycle N produces registered outputs in cycle N+1, each held for exactly 1 cycle:
//     upd_valid=ex_is_branch; upd_pc=ex_pc; upd_tar=ex_tar; upd_taken=ex_taken
//     flush_o=M; redirect_pc per the table above
//     br_cnt+=ex_is_branch; miss_cnt+=M (both wrap modulo 2^CW)
//   On M in cycle N, the queue is cleared at the end of N.
//     A simultaneous push in cycle N is discarded (wrong path).
//   While flush_o=1 (cycle N+1), if_push and ex_valid are ignored.
//     Normal operation resumes in N+2.
//   upd_tar/upd_pc hold their last values when upd_valid=0.
//   Reset asserted mid-flush or mid-update: the pulse is cancelled and the queue is emptied.
// TESTING
//   1. Push pc=0x100 pred_taken=1 tar=0x200; EX resolves pc=0x100 taken tar=0x200
//        -> next cycle upd_valid=1, upd_taken=1, flush_o=0, br_cnt=1, miss_cnt=0.
//   2. Push 0x100 pred_taken=0; resolve branch taken tar=0x180
//        -> flush_o=1, redirect_pc=0x180, miss_cnt=1, queue empty;
//        a push in the resolve cycle is dropped.
//   3. Push 0x40 pred_taken=1 (aliased, non-branch); resolve ex_is_branch=0
//        -> upd_valid=0, flush_o=1, redirect_pc=0x44.
//   4. Push 4 entries (DEPTH=4) -> q_full=1; push+pop same cycle -> count stays 4;
//        push alone while full -> dropped, err_o=1.
//   5. rdy=0 during the cycle after a mispredict
//        -> flush_o=0 until rdy=1, then a single 1-cycle pulse; counters unchanged while frozen.
//   6. ex_valid with empty queue -> err_o=1, no upd_valid;
//        rst mid-sequence -> all outputs 0 next cycle.

Source files
------------

// File: rtl/branch_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : branch_resolver                                            |
// | Description : Tracks IF-stage predictions in an in-order queue, checks   |
// |               them against EX resolution, drives the predictor update    |
// |               bus, raises flush/redirect on a mispredict and keeps       |
// |               branch/mispredict statistics.                              |
// | Ports       : clk, rst          - clock, synchronous active-high reset   |
// |               rdy               - global enable (0 freezes all state)    |
// |               if_push/if_pc/pred_taken/pred_tar - prediction at IF       |
// |               q_full            - tracking queue full, IF must stall     |
// |               ex_valid/ex_pc/ex_is_branch/ex_taken/ex_tar - EX outcome   |
// |               upd_valid/upd_pc/upd_tar/upd_taken - predictor update      |
// |               flush_o/redirect_pc - mispredict flush and correct PC      |
// |               br_cnt/miss_cnt   - resolved branch / mispredict counts    |
// |               err_o             - sticky protocol error                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module branch_resolver #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int CW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rdy,
   input  logic          if_push,
   input  logic [AW-1:0] if_pc,
   input  logic          pred_taken,
   input  logic [AW-1:0] pred_tar,
   output logic          q_full,
   input  logic          ex_valid,
   input  logic [AW-1:0] ex_pc,
   input  logic          ex_is_branch,
   input  logic          ex_taken,
   input  logic [AW-1:0] ex_tar,
   output logic          upd_valid,
   output logic [AW-1:0] upd_pc,
   output logic [AW-1:0] upd_tar,
   output logic          upd_taken,
   output logic          flush_o,
   output logic [AW-1:0] redirect_pc,
   output logic [CW-1:0] br_cnt,
   output logic [CW-1:0] miss_cnt,
   output logic          err_o
);

   localparam int            c_pw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_pw:0] c_depth = (c_pw + 1)'(DEPTH);

   // Queue storage and control
   logic [AW-1:0] ent_pc_q    [DEPTH];
   logic [AW-1:0] ent_tar_q   [DEPTH];
   logic          ent_taken_q [DEPTH];

   logic [c_pw-1:0] head_q, head_d;
   logic [c_pw-1:0] tail_q, tail_d;
   logic [c_pw:0]   count_q, count_d;

   // Registered outputs
   logic          upd_valid_q, upd_valid_d;
   logic [AW-1:0] upd_pc_q, upd_pc_d;
   logic [AW-1:0] upd_tar_q, upd_tar_d;
   logic          upd_taken_q, upd_taken_d;
   logic          flush_q, flush_d;
   logic [AW-1:0] redirect_q, redirect_d;
   logic [CW-1:0] br_cnt_q, br_cnt_d;
   logic [CW-1:0] miss_cnt_q, miss_cnt_d;
   logic          err_q, err_d;

   // Per-cycle decode
   logic          w_act_push;
   logic          w_act_ex;
   logic          w_pop;
   logic          w_miss;
   logic          w_push_ok;
   logic          w_err_evt;
   logic [AW-1:0] w_head_pc;
   logic [AW-1:0] w_head_tar;
   logic          w_head_taken;
   logic [AW-1:0] w_nxt_pc;
   logic [AW-1:0] w_redir;

   always_comb begin
      // The cycle in which flush_o is presented carries wrong-path traffic,
      // so IF and EX requests are ignored then.
      w_act_push   = if_push & ~flush_q;
      w_act_ex     = ex_valid & ~flush_q;
      w_pop        = w_act_ex & (count_q != '0);
      w_head_pc    = ent_pc_q[head_q];
      w_head_tar   = ent_tar_q[head_q];
      w_head_taken = ent_taken_q[head_q];
      w_nxt_pc     = ex_pc + AW'(4);

      w_miss = 1'b0;
      if (w_pop) begin
         if (ex_is_branch && ex_taken)
            w_miss = ~w_head_taken | (w_head_tar != ex_tar);
         else
            w_miss = w_head_taken;
      end
      w_redir = (ex_is_branch && ex_taken) ? ex_tar : w_nxt_pc;

      // A pop frees a slot in the same cycle; a mispredict discards the push.
      w_push_ok = w_act_push & ((count_q != c_depth) | w_pop) & ~w_miss;

      w_err_evt = (w_act_push & (count_q == c_depth) & ~w_pop)
                | (w_act_ex & (count_q == '0))
                | (w_pop & (ex_pc != w_head_pc));

      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      upd_valid_d = upd_valid_q;
      upd_pc_d    = upd_pc_q;
      upd_tar_d   = upd_tar_q;
      upd_taken_d = upd_taken_q;
      flush_d     = flush_q;
      redirect_d  = redirect_q;
      br_cnt_d    = br_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_d       = err_q;

      // With rdy low everything holds, including undelivered pulses.
      if (rdy) begin
         upd_valid_d = 1'b0;
         flush_d     = 1'b0;

         if (w_pop) begin
            upd_valid_d = ex_is_branch;
            upd_pc_d    = ex_pc;
            upd_tar_d   = ex_tar;
            upd_taken_d = ex_taken;
            flush_d     = w_miss;
            redirect_d  = w_redir;
            br_cnt_d    = br_cnt_q + CW'(ex_is_branch);
            miss_cnt_d  = miss_cnt_q + CW'(w_miss);
            head_d      = head_q + 1'b1;
         end

         if (w_push_ok)
            tail_d = tail_q + 1'b1;

         count_d = count_q + (c_pw + 1)'(w_push_ok) - (c_pw + 1)'(w_pop);

         if (w_miss) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end

         if (w_err_evt)
            err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         upd_valid_q <= 1'b0;
         upd_pc_q    <= '0;
         upd_tar_q   <= '0;
         upd_taken_q <= 1'b0;
         flush_q     <= 1'b0;
         redirect_q  <= '0;
         br_cnt_q    <= '0;
         miss_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         upd_valid_q <= upd_valid_d;
         upd_pc_q    <= upd_pc_d;
         upd_tar_q   <= upd_tar_d;
         upd_taken_q <= upd_taken_d;
         flush_q     <= flush_d;
         redirect_q  <= redirect_d;
         br_cnt_q    <= br_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_q       <= err_d;
      end
   end

   // Entry payload needs no reset: it is only read while count is non-zero.
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_entry
         always_ff @(posedge clk) begin
            if (!rst && rdy && w_push_ok && (tail_q == c_pw'(i))) begin
               ent_pc_q[i]    <= if_pc;
               ent_tar_q[i]   <= pred_tar;
               ent_taken_q[i] <= pred_taken;
            end
         end
      end
   endgenerate

   assign q_full      = (count_q == c_depth);
   assign upd_valid   = upd_valid_q & rdy;
   assign upd_pc      = upd_pc_q;
   assign upd_tar     = upd_tar_q;
   assign upd_taken   = upd_taken_q;
   assign flush_o     = flush_q & rdy;
   assign redirect_pc = redirect_q;
   assign br_cnt      = br_cnt_q;
   assign miss_cnt    = miss_cnt_q;
   assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_branch_resolver                                         |
// | Description : Self-checking bench for branch_resolver: directed          |
// |               scenarios followed by randomized traffic, all compared     |
// |               against a queue-based reference model.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_branch_resolver;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int CW    = 32;

   logic          clk = 1'b0;
   logic          rst, rdy, if_push, pred_taken, ex_valid, ex_is_branch, ex_taken;
   logic [AW-1:0] if_pc, pred_tar, ex_pc, ex_tar;
   logic          q_full, upd_valid, upd_taken, flush_o, err_o;
   logic [AW-1:0] upd_pc, upd_tar, redirect_pc;
   logic [CW-1:0] br_cnt, miss_cnt;

   branch_resolver #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_push(if_push), .if_pc(if_pc), .pred_taken(pred_taken), .pred_tar(pred_tar),
      .q_full(q_full),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
      .ex_taken(ex_taken), .ex_tar(ex_tar),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_tar(upd_tar), .upd_taken(upd_taken),
      .flush_o(flush_o), .redirect_pc(redirect_pc),
      .br_cnt(br_cnt), .miss_cnt(miss_cnt), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: in-flight predictions as a plain queue
   typedef struct packed {
      logic [AW-1:0] pc;
      logic          pt;
      logic [AW-1:0] tar;
   } ent_t;

   ent_t          mq[$];
   bit            e_uv, e_fl, e_ut, e_err;
   logic [AW-1:0] e_pc, e_tar, e_redir;
   logic [CW-1:0] e_br, e_miss;

   task automatic model_reset();
      mq.delete();
      e_uv = 0; e_fl = 0; e_ut = 0; e_err = 0;
      e_pc = '0; e_tar = '0; e_redir = '0; e_br = '0; e_miss = '0;
   endtask

   // Advance the model across one clock edge using the currently driven inputs.
   task automatic model_step();
      bit   in_flush, pop, m, nv, nf;
      ent_t h;
      if (rst) begin
         model_reset();
         return;
      end
      if (!rdy) return;
      in_flush = e_fl;
      nv = 0; nf = 0; m = 0; pop = 0;
      if (!in_flush) begin
         if (ex_valid && mq.size() == 0) e_err = 1;
         pop = ex_valid && mq.size() > 0;
         if (pop) begin
            h = mq[0];
            if (ex_pc != h.pc) e_err = 1;
            if (ex_is_branch && ex_taken) m = !h.pt || (h.tar != ex_tar);
            else                          m = h.pt;
            e_pc  = ex_pc;
            e_tar = ex_tar;
            e_ut  = ex_taken;
            e_redir = (ex_is_branch && ex_taken) ? ex_tar : ex_pc + 32'd4;
            e_br   = e_br + CW'(ex_is_branch);
            e_miss = e_miss + CW'(m);
            nv = ex_is_branch;
            nf = m;
         end
         if (if_push && !m) begin
            if (mq.size() < DEPTH || pop) begin
               if (pop) void'(mq.pop_front());
               pop = 0;
               mq.push_back('{pc: if_pc, pt: pred_taken, tar: pred_tar});
            end else begin
               e_err = 1;
            end
         end
         if (pop) void'(mq.pop_front());
         if (m) mq.delete();
      end
      e_uv = nv;
      e_fl = nf;
   endtask

   task automatic compare_outputs();
      chk("q_full",    q_full,    mq.size() == DEPTH);
      chk("upd_valid", upd_valid, e_uv & rdy);
      chk("flush_o",   flush_o,   e_fl & rdy);
      if (e_fl && rdy)  chk("redirect_pc", redirect_pc, e_redir);
      if (e_uv && rdy)  chk("upd_taken",   upd_taken,   e_ut);
      chk("upd_pc",   upd_pc,   e_pc);
      chk("upd_tar",  upd_tar,  e_tar);
      chk("br_cnt",   br_cnt,   e_br);
      chk("miss_cnt", miss_cnt, e_miss);
      chk("err_o",    err_o,    e_err);
   endtask

   // Drive one cycle of inputs, check visible outputs, then cross the edge.
   task automatic step(input bit r, input bit rd,
                       input bit ip, input logic [AW-1:0] ipc, input bit pt, input logic [AW-1:0] ptar,
                       input bit ev, input logic [AW-1:0] epc, input bit eb, input bit et,
                       input logic [AW-1:0] etar);
      rst = r; rdy = rd;
      if_push = ip; if_pc = ipc; pred_taken = pt; pred_tar = ptar;
      ex_valid = ev; ex_pc = epc; ex_is_branch = eb; ex_taken = et; ex_tar = etar;
      #1;
      compare_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit rd);
      step(0, rd, 0, '0, 0, '0, 0, '0, 0, 0, '0);
   endtask

   task automatic do_reset();
      step(1, 1, 0, '0, 0, '0, 0, '0, 0, 0, '0);
   endtask

   initial begin
      rst = 1; rdy = 1; if_push = 0; if_pc = '0; pred_taken = 0; pred_tar = '0;
      ex_valid = 0; ex_pc = '0; ex_is_branch = 0; ex_taken = 0; ex_tar = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      #1;
      chk("rst_q_full", q_full, 0);
      chk("rst_upd_valid", upd_valid, 0);
      chk("rst_flush", flush_o, 0);
      chk("rst_err", err_o, 0);

      // Correct taken prediction
      do_reset();
      step(0, 1, 1, 32'h100, 1, 32'h200, 0, '0, 0, 0, '0);
      step(0, 1, 0, '0, 0, '0, 1, 32'h100, 1, 1, 32'h200);
      chk("t1_upd_valid", upd_valid, 1);
      chk("t1_upd_taken", upd_taken, 1);
      chk("t1_flush", flush_o, 0);
      chk("t1_br_cnt", br_cnt, 1);
      chk("t1_miss_cnt", miss_cnt, 0);
      idle(1);

      // Not-taken prediction, branch taken; push in resolve cycle dropped
      do_reset();
      step(0, 1, 1, 32'h100, 0, 32'h0, 0, '0, 0, 0, '0);
      step(0, 1, 1, 32'h104, 0, 32'h0, 1, 32'h100, 1, 1, 32'h180);
      chk("t2_flush", flush_o, 1);
      chk("t2_redirect", redirect_pc, 32'h180);
      chk("t2_miss_cnt", miss_cnt, 1);
      idle(1);
      step(0, 1, 0, '0, 0, '0, 1, 32'h104, 0, 0, '0);
      chk("t2_q_empty_err", err_o, 1);

      // Aliased prediction on a non-branch
      do_reset();
      step(0, 1, 1, 32'h40, 1, 32'h80, 0, '0, 0, 0, '0);
      step(0, 1, 0, '0, 0, '0, 1, 32'h40, 0, 0, '0);
      chk("t3_upd_valid", upd_valid, 0);
      chk("t3_flush", flush_o, 1);
      chk("t3_redirect", redirect_pc, 32'h44);
      idle(1);

      // Full queue handling
      do_reset();
      for (int i = 0; i < DEPTH; i++)
         step(0, 1, 1, 32'h10 + 32'(4 * i), 0, '0, 0, '0, 0, 0, '0);
      chk("t4_full", q_full, 1);
      step(0, 1, 1, 32'h20, 0, '0, 1, 32'h10, 0, 0, '0);
      chk("t4_full_pp", q_full, 1);
      chk("t4_no_err", err_o, 0);
      step(0, 1, 1, 32'h24, 0, '0, 0, '0, 0, 0, '0);
      chk("t4_drop_err", err_o, 1);
      idle(1);

      // Frozen flush pulse
      do_reset();
      step(0, 1, 1, 32'h100, 0, '0, 0, '0, 0, 0, '0);
      step(0, 1, 0, '0, 0, '0, 1, 32'h100, 1, 1, 32'h300);
      idle(0);
      chk("t5_frozen_flush", flush_o, 0);
      chk("t5_frozen_miss", miss_cnt, 1);
      idle(0);
      idle(1);
      idle(1);

      // Empty-queue resolve and mid-sequence reset
      do_reset();
      step(0, 1, 0, '0, 0, '0, 1, 32'h500, 1, 1, 32'h600);
      chk("t6_err", err_o, 1);
      chk("t6_upd_valid", upd_valid, 0);
      step(0, 1, 1, 32'h700, 0, '0, 0, '0, 0, 0, '0);
      step(0, 1, 0, '0, 0, '0, 1, 32'h700, 1, 1, 32'h900);
      do_reset();
      chk("t6_rst_flush", flush_o, 0);
      chk("t6_rst_uv", upd_valid, 0);
      chk("t6_rst_pc", upd_pc, 0);
      chk("t6_rst_taken", upd_taken, 0);
      chk("t6_rst_redir", redirect_pc, 0);
      chk("t6_rst_br", br_cnt, 0);
      chk("t6_rst_err", err_o, 0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bit            r, rd, ip, pt, ev, eb, et;
         logic [AW-1:0] ipc, ptar, epc, etar;
         r   = ($urandom_range(0, 199) == 0);
         rd  = ($urandom_range(0, 9) != 0);
         ip  = ($urandom_range(0, 9) < 6);
         ipc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         pt  = $urandom_range(0, 1);
         ptar = ($urandom() & 32'h0000_0FFC);
         ev  = ($urandom_range(0, 1) == 1);
         eb  = ($urandom_range(0, 9) < 7);
         et  = $urandom_range(0, 1);
         etar = ($urandom() & 32'h0000_0FFC);
         epc  = ($urandom() & 32'hFFFF_FFFC);
         if (mq.size() > 0) begin
            if ($urandom_range(0, 9) != 0) epc = mq[0].pc;
            if ($urandom_range(0, 1) == 1) etar = mq[0].tar;
         end
         step(r, rd, ip, ipc, pt, ptar, ev, epc, eb, et, etar);
      end
      idle(1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
